// File: rtl/cursor_tracker_if.sv
// Packet and result signals between the PS/2 decoder side and cursor_tracker.
// Listo is a one-cycle strobe: fields are valid only in that cycle, and the strobe is dropped while Ocupado=1.
interface cursor_tracker_if;
  logic       Listo;
  logic       Click;
  logic       Izquierda;
  logic       Derecha;
  logic       Arriba;
  logic       Abajo;
  logic [7:0] MagX;
  logic [7:0] MagY;
  logic [9:0] PosX;
  logic [8:0] PosY;
  logic       Actualizado;
  logic       ClickPulso;
  logic       DobleClick;
  logic       Ocupado;

  modport master (
    output Listo, Click, Izquierda, Derecha, Arriba, Abajo, MagX, MagY,
    input  PosX, PosY, Actualizado, ClickPulso, DobleClick, Ocupado
  );

  modport slave (
    input  Listo, Click, Izquierda, Derecha, Arriba, Abajo, MagX, MagY,
    output PosX, PosY, Actualizado, ClickPulso, DobleClick, Ocupado
  );
endinterface

// File: rtl/cursor_tracker.sv
// Saturating cursor position from decoded mouse packets, plus click and double-click pulses.
// One packet per four cycles: latch, update X, update Y, publish.
module cursor_tracker #(
  parameter int ANCHO         = 640,
  parameter int ALTO          = 480,
  parameter int X_INI         = 320,
  parameter int Y_INI         = 240,
  parameter int ESCALA        = 0,
  parameter int VENTANA_DOBLE = 25_000_000
) (
  input  logic         Clk,
  input  logic         Reset,
  cursor_tracker_if.slave bus,
  output logic [1:0]   estado
);

  localparam int CW = $clog2(VENTANA_DOBLE + 1);
  localparam logic [CW-1:0] VENTANA = CW'(VENTANA_DOBLE);
  localparam logic [10:0]   X_MAX   = 11'(ANCHO - 1);
  localparam logic [10:0]   Y_MAX   = 11'(ALTO - 1);

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    CALC_X   = 2'd1,
    CALC_Y   = 2'd2,
    PUBLICAR = 2'd3
  } estado_t;

  estado_t state, next_state;

  logic       lat_click, lat_izq, lat_der, lat_arr, lat_aba;
  logic [7:0] lat_dx, lat_dy;
  logic [9:0] pos_x, x_next;
  logic [8:0] pos_y, y_next;
  logic       prev_click;
  logic       actualizado, click_pulso, doble_click, ocupado;
  logic       armed;
  logic [CW-1:0] cnt;
  logic       click_press;
  logic [10:0] x_ext, dx_ext, x_sum;
  logic [10:0] y_ext, dy_ext, y_sum;

  assign estado          = state;
  assign bus.PosX        = pos_x;
  assign bus.PosY        = pos_y;
  assign bus.Actualizado = actualizado;
  assign bus.ClickPulso  = click_pulso;
  assign bus.DobleClick  = doble_click;
  assign bus.Ocupado     = ocupado;

  always_ff @(posedge Clk) begin
    if (Reset) state <= ESPERA;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ESPERA:   if (bus.Listo) next_state = CALC_X;
      CALC_X:   next_state = CALC_Y;
      CALC_Y:   next_state = PUBLICAR;
      PUBLICAR: next_state = ESPERA;
      default:  next_state = ESPERA;
    endcase
  end

  // 11-bit intermediates so neither the sum nor the comparison can wrap.
  always_comb begin
    x_ext  = {1'b0, pos_x};
    dx_ext = {3'b000, lat_dx};
    x_sum  = x_ext + dx_ext;
    x_next = pos_x;
    if (lat_der && !lat_izq)
      x_next = (x_sum > X_MAX) ? X_MAX[9:0] : x_sum[9:0];
    else if (lat_izq && !lat_der)
      x_next = (dx_ext > x_ext) ? 10'd0 : 10'(x_ext - dx_ext);
  end

  always_comb begin
    y_ext  = {2'b00, pos_y};
    dy_ext = {3'b000, lat_dy};
    y_sum  = y_ext + dy_ext;
    y_next = pos_y;
    if (lat_aba && !lat_arr)
      y_next = (y_sum > Y_MAX) ? Y_MAX[8:0] : y_sum[8:0];
    else if (lat_arr && !lat_aba)
      y_next = (dy_ext > y_ext) ? 9'd0 : 9'(y_ext - dy_ext);
  end

  // Press detected one cycle ahead so the registered pulses land in PUBLICAR.
  assign click_press = (state == CALC_Y) && lat_click && !prev_click;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pos_x       <= 10'(X_INI);
      pos_y       <= 9'(Y_INI);
      lat_click   <= 1'b0;
      lat_izq     <= 1'b0;
      lat_der     <= 1'b0;
      lat_arr     <= 1'b0;
      lat_aba     <= 1'b0;
      lat_dx      <= 8'd0;
      lat_dy      <= 8'd0;
      prev_click  <= 1'b0;
      actualizado <= 1'b0;
      click_pulso <= 1'b0;
      doble_click <= 1'b0;
      ocupado     <= 1'b0;
      armed       <= 1'b0;
      cnt         <= '0;
    end else begin
      ocupado     <= (next_state != ESPERA);
      actualizado <= (state == CALC_Y);
      click_pulso <= click_press;
      doble_click <= click_press && armed && (cnt < VENTANA);

      case (state)
        ESPERA: begin
          if (bus.Listo) begin
            lat_click <= bus.Click;
            lat_izq   <= bus.Izquierda;
            lat_der   <= bus.Derecha;
            lat_arr   <= bus.Arriba;
            lat_aba   <= bus.Abajo;
            lat_dx    <= bus.MagX >> ESCALA;
            lat_dy    <= bus.MagY >> ESCALA;
          end
        end
        CALC_X:   pos_x <= x_next;
        CALC_Y:   pos_y <= y_next;
        PUBLICAR: prev_click <= lat_click;
        default: ;
      endcase

      // A press inside the window consumes the arming; otherwise it re-arms.
      if (click_press) begin
        if (armed && (cnt < VENTANA)) begin
          armed <= 1'b0;
        end else begin
          armed <= 1'b1;
          cnt   <= '0;
        end
      end else if (armed) begin
        if (cnt == VENTANA) armed <= 1'b0;
        else                cnt   <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cursor_tracker.sv
// Bench for cursor_tracker: two instances (ESCALA 0 and 2) share one stimulus stream
// and are checked against a cycle-stamped arithmetic model of the packet rules.
module tb_cursor_tracker;
  localparam int VENT  = 100;
  localparam int W     = 40;
  localparam int ESC_B = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] estado_a, estado_b;

  cursor_tracker_if bus_a ();
  cursor_tracker_if bus_b ();

  assign bus_b.Listo     = bus_a.Listo;
  assign bus_b.Click     = bus_a.Click;
  assign bus_b.Izquierda = bus_a.Izquierda;
  assign bus_b.Derecha   = bus_a.Derecha;
  assign bus_b.Arriba    = bus_a.Arriba;
  assign bus_b.Abajo     = bus_a.Abajo;
  assign bus_b.MagX      = bus_a.MagX;
  assign bus_b.MagY      = bus_a.MagY;

  cursor_tracker #(.ANCHO(640), .ALTO(480), .X_INI(320), .Y_INI(240),
                   .ESCALA(0), .VENTANA_DOBLE(VENT))
    dut_a (.Clk(Clk), .Reset(Reset), .bus(bus_a.slave), .estado(estado_a));

  cursor_tracker #(.ANCHO(640), .ALTO(480), .X_INI(320), .Y_INI(240),
                   .ESCALA(ESC_B), .VENTANA_DOBLE(VENT))
    dut_b (.Clk(Clk), .Reset(Reset), .bus(bus_b.slave), .estado(estado_b));

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- reference model / scoreboard ----------------
  int   ex[2];
  int   ey[2];
  logic m_prev;
  logic m_armed;
  int   m_tarm;
  logic [W-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ex[i] = 320;
      ey[i] = 240;
    end
    m_prev  = 1'b0;
    m_armed = 1'b0;
    m_tarm  = 0;
    exp_q.delete();
  endtask

  function automatic int move(input int p, input int d, input logic neg,
                              input logic pos, input int maxv);
    int r;
    r = p;
    if (pos && !neg) r = (p + d > maxv) ? maxv : p + d;
    else if (neg && !pos) r = (d > p) ? 0 : p - d;
    return r;
  endfunction

  task automatic model_accept(input logic c, iz, de, ar, ab,
                              input logic [7:0] mx, my, input int t);
    int   esc;
    logic pr, dbl;
    for (int i = 0; i < 2; i++) begin
      esc   = (i == 0) ? 0 : ESC_B;
      ex[i] = move(ex[i], int'(mx) >> esc, iz, de, 639);
      ey[i] = move(ey[i], int'(my) >> esc, ar, ab, 479);
    end
    pr     = c && !m_prev;
    m_prev = c;
    dbl    = 1'b0;
    if (pr) begin
      if (m_armed && (t - m_tarm) <= VENT) begin
        dbl     = 1'b1;
        m_armed = 1'b0;
      end else begin
        m_armed = 1'b1;
        m_tarm  = t;
      end
    end
    exp_q.push_back({10'(ex[0]), 9'(ey[0]), 10'(ex[1]), 9'(ey[1]), pr, dbl});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks the publish cycle against the next scoreboard entry.
  task automatic check_publish(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_act_a"},  bus_a.Actualizado, 1);
    chk({tag, "_act_b"},  bus_b.Actualizado, 1);
    chk({tag, "_x_a"},    bus_a.PosX, e[39:30]);
    chk({tag, "_y_a"},    bus_a.PosY, e[29:21]);
    chk({tag, "_x_b"},    bus_b.PosX, e[20:11]);
    chk({tag, "_y_b"},    bus_b.PosY, e[10:2]);
    chk({tag, "_clk_a"},  bus_a.ClickPulso, e[1]);
    chk({tag, "_clk_b"},  bus_b.ClickPulso, e[1]);
    chk({tag, "_dbl_a"},  bus_a.DobleClick, e[0]);
    chk({tag, "_dbl_b"},  bus_b.DobleClick, e[0]);
    chk({tag, "_busy3"},  bus_a.Ocupado, 1);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic c, iz, de, ar, ab, input logic [7:0] mx, my);
    bus_a.Click     = c;
    bus_a.Izquierda = iz;
    bus_a.Derecha   = de;
    bus_a.Arriba    = ar;
    bus_a.Abajo     = ab;
    bus_a.MagX      = mx;
    bus_a.MagY      = my;
    bus_a.Listo     = 1'b1;
  endtask

  task automatic do_reset();
    bus_a.Listo = 1'b0;
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    model_reset();
  endtask

  // Listo in cycle N; returns in cycle N+4, ready for the next packet.
  task automatic run_packet(input logic c, iz, de, ar, ab,
                            input logic [7:0] mx, my, input string tag);
    drive(c, iz, de, ar, ab, mx, my);
    model_accept(c, iz, de, ar, ab, mx, my, cyc);
    step();
    bus_a.Listo = 1'b0;
    chk({tag, "_busy1"}, bus_a.Ocupado, 1);
    chk({tag, "_noact1"}, bus_a.Actualizado, 0);
    step();
    chk({tag, "_busy2"}, bus_b.Ocupado, 1);
    step();
    check_publish(tag);
    step();
    chk({tag, "_idle4"}, bus_a.Ocupado, 0);
    chk({tag, "_noact4"}, bus_a.Actualizado, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic c, iz, de, ar, ab;
    logic [7:0] mx, my;

    Reset = 1'b0;
    bus_a.Listo = 1'b0;
    drive(0, 0, 0, 0, 0, 8'd0, 8'd0);
    bus_a.Listo = 1'b0;
    step();

    do_reset();
    chk("rst_x",    bus_a.PosX, 320);
    chk("rst_y",    bus_a.PosY, 240);
    chk("rst_act",  bus_a.Actualizado, 0);
    chk("rst_clk",  bus_a.ClickPulso, 0);
    chk("rst_dbl",  bus_a.DobleClick, 0);
    chk("rst_busy", bus_a.Ocupado, 0);

    run_packet(0, 0, 1, 0, 1, 8'd10, 8'd5, "basic");
    chk("basic_lit_x", bus_a.PosX, 330);
    chk("basic_lit_y", bus_a.PosY, 245);

    do_reset();
    run_packet(0, 1, 0, 0, 0, 8'd255, 8'd0, "left1");
    chk("left1_lit_x", bus_a.PosX, 65);
    run_packet(0, 1, 0, 0, 0, 8'd255, 8'd0, "left2");
    chk("left2_lit_x", bus_a.PosX, 0);
    run_packet(0, 0, 0, 0, 1, 8'd0, 8'd255, "down1");
    run_packet(0, 0, 0, 0, 1, 8'd0, 8'd255, "down2");
    chk("down2_lit_y", bus_a.PosY, 479);
    run_packet(0, 0, 0, 1, 0, 8'd0, 8'd255, "up1");
    run_packet(0, 0, 0, 1, 0, 8'd0, 8'd255, "up2");

    run_packet(0, 1, 1, 1, 1, 8'd50, 8'd50, "both");
    run_packet(0, 0, 1, 0, 0, 8'd13, 8'd0, "esc13");
    run_packet(0, 0, 1, 0, 0, 8'd255, 8'd0, "right1");
    run_packet(0, 0, 1, 0, 0, 8'd255, 8'd0, "right2");
    run_packet(0, 0, 1, 0, 0, 8'd255, 8'd0, "right3");

    // presses 40 cycles apart: second one is a double click
    run_packet(1, 0, 0, 0, 0, 8'd0, 8'd0, "dc_p1");
    run_packet(0, 0, 0, 0, 0, 8'd0, 8'd0, "dc_r1");
    idle(32);
    run_packet(1, 0, 0, 0, 0, 8'd0, 8'd0, "dc_p2");
    chk("dc_p2_lit", bus_a.DobleClick, 0);
    // presses 150 cycles apart: no double click
    run_packet(0, 0, 0, 0, 0, 8'd0, 8'd0, "sc_r0");
    run_packet(1, 0, 0, 0, 0, 8'd0, 8'd0, "sc_p1");
    run_packet(0, 0, 0, 0, 0, 8'd0, 8'd0, "sc_r1");
    idle(142);
    run_packet(1, 0, 0, 0, 0, 8'd0, 8'd0, "sc_p2");

    // Listo held through N+2: only the first strobe is taken
    drive(0, 0, 1, 0, 1, 8'd7, 8'd9);
    model_accept(0, 0, 1, 0, 1, 8'd7, 8'd9, cyc);
    step();
    step();
    step();
    bus_a.Listo = 1'b0;
    check_publish("drop");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("drop_noact", bus_a.Actualizado, 0);
      chk("drop_idle",  bus_a.Ocupado, 0);
    end

    // reset in N+2 aborts the packet
    run_packet(0, 0, 1, 0, 1, 8'd40, 8'd40, "pre_abort");
    drive(1, 0, 1, 0, 1, 8'd100, 8'd100);
    step();
    bus_a.Listo = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    model_reset();
    chk("abort_act",  bus_a.Actualizado, 0);
    chk("abort_clk",  bus_a.ClickPulso, 0);
    chk("abort_x",    bus_a.PosX, 320);
    chk("abort_y",    bus_a.PosY, 240);
    chk("abort_busy", bus_a.Ocupado, 0);
    step();
    chk("abort_act2", bus_a.Actualizado, 0);
    chk("abort_xb",   bus_b.PosX, 320);

    // randomized packets with random gaps
    for (int n = 0; n < 60; n++) begin
      c  = 1'($urandom_range(0, 1));
      iz = 1'($urandom_range(0, 1));
      de = 1'($urandom_range(0, 1));
      ar = 1'($urandom_range(0, 1));
      ab = 1'($urandom_range(0, 1));
      mx = 8'($urandom_range(0, 255));
      my = 8'($urandom_range(0, 255));
      run_packet(c, iz, de, ar, ab, mx, my, "rnd");
      idle($urandom_range(0, 40));
    end

    chk("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cursor_tracker.md
# cursor_tracker

Downstream consumer of the PS/2 mouse decoder (`controlMouse`). It takes each decoded movement packet (button, direction flags and 8-bit magnitudes) and keeps a saturating on-screen cursor position for the VGA display stage. It also produces a single-cycle click pulse and a double-click pulse for the application logic.

## Interface
Parameters:
- `ANCHO`, 640: screen width in pixels; X range is 0..ANCHO-1.
- `ALTO`, 480: screen height in pixels; Y range is 0..ALTO-1.
- `X_INI`, 320: X position after reset.
- `Y_INI`, 240: Y position after reset.
- `ESCALA`, 0: right-shift applied to MagX/MagY before accumulation (speed divider).
- `VENTANA_DOBLE`, 25_000_000: double-click window, in Clk cycles.

Ports:
- `Clk`  in  1  system clock; single clock domain.
- `Reset`  in  1  synchronous, active-high reset.
- `Listo`  in  1  one-cycle strobe; packet fields below are stable and valid in this cycle.
- `Click`  in  1  left button state from the packet.
- `Izquierda`, `Derecha`  in  1 each  X direction flags.
- `Arriba`, `Abajo`  in  1 each  Y direction flags.
- `MagX`, `MagY`  in  8 each  unsigned movement magnitudes.
- `PosX`  out  10  cursor X.
- `PosY`  out  9  cursor Y.
- `Actualizado`  out  1  one-cycle pulse when PosX/PosY hold a newly published value.
- `ClickPulso`  out  1  one-cycle pulse on a button press (0→1 between packets).
- `DobleClick`  out  1  one-cycle pulse on the second press inside the window.
- `Ocupado`  out  1  high while a packet is being processed.

## Operation
- FSM states: ESPERA, CALC_X, CALC_Y, PUBLICAR.
  - ESPERA (Ocupado=0): when Listo=1, latch all packet fields, then go to CALC_X.
  - CALC_X → CALC_Y → PUBLICAR → ESPERA, one cycle each, unconditionally.
- Delta: dX = MagX >> ESCALA, dY = MagY >> ESCALA.
- Arithmetic uses 11-bit unsigned intermediates, so no wrap-around is possible.
- X update (CALC_X):
  - Derecha only: X + dX, clamped to ANCHO-1.
  - Izquierda only: X − dX, clamped to 0 when dX > X.
  - Both flags or neither: X unchanged.
- Y update (CALC_Y), screen coordinates:
  - Abajo only: Y + dY, clamped to ALTO-1.
  - Arriba only: Y − dY, clamped to 0.
  - Both flags or neither: Y unchanged.
- PUBLICAR:
  - Actualizado=1.
  - ClickPulso=1 if the latched Click=1 and the previous packet's Click=0.
  - Store the latched Click as the previous click state.
- Double-click counter:
  - Disarmed after reset.
  - A ClickPulso while disarmed arms it and clears it to 0.
  - While armed, it increments each cycle and disarms on reaching VENTANA_DOBLE.
  - A ClickPulso while armed and count < VENTANA_DOBLE: DobleClick=1 in the same cycle as that ClickPulso, and the counter disarms. A third quick press therefore re-arms rather than giving another DobleClick.
- Listo asserted while Ocupado=1 is ignored and the packet is dropped; no queueing.

## Timing
- Listo sampled in cycle N:
  - Ocupado is high in cycles N+1..N+3.
  - Actualizado, ClickPulso and DobleClick pulse in cycle N+3.
  - PosX/PosY show the new value no later than N+3; PosX may change at N+2.
- Back-to-back throughput: Listo is accepted again at N+4, i.e. one packet per 4 cycles maximum.
- All outputs are registered.
- Reset values: PosX=X_INI, PosY=Y_INI, Actualizado=0, ClickPulso=0, DobleClick=0, Ocupado=0, state=ESPERA, previous click=0, counter disarmed.
- Reset asserted mid-packet aborts the packet. No publish pulse follows, and position returns to X_INI/Y_INI.
- Reset has priority over Listo in the same cycle.

## Test plan
- Reset → PosX=320, PosY=240, all pulses 0, Ocupado=0.
- Listo with Derecha=1, MagX=10, Abajo=1, MagY=5 at cycle N → Actualizado at N+3, PosX=330, PosY=245.
- Two packets with Izquierda=1, MagX=255 from 320 → PosX=65, then 0 (saturated). Then Abajo=1, MagY=255 twice → PosY=479.
- Izquierda=Derecha=1, MagX=50 → PosX unchanged, Actualizado still pulses. With ESCALA=2, Derecha and MagX=13 → +3.
- VENTANA_DOBLE=100, packet sequence Click 1,0,1 with presses 40 cycles apart → ClickPulso on both presses, DobleClick on the second. Repeat with presses 150 cycles apart → no DobleClick.
- Listo re-asserted at N+1 and N+2 → ignored, only one update.
- Reset at N+2 → no Actualizado, PosX/PosY=320/240.
